pid_reg_arbiter: RTL and testbench

//  Shares the single-port-write / registered-read PID register file between two masters:
//  req0 = host command decoder (UART), req1 = startup/config sequencer.

---
 rtl/pid_regs_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 33 +++
 rtl/pid_reg_arbiter.sv | 162 ++++++++++++++++
 tb/tb_pid_reg_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_regs_pkg.sv
// Shared constants and types for the PID register file and its access arbiter.
// Register map: tuning/config registers at the bottom, read-only status at the top.
package pid_regs_pkg;

    localparam int unsigned PID_ADDR_W = 8;
    localparam int unsigned PID_DATA_W = 16;
    localparam int unsigned PID_DEPTH  = 16;

    // Status registers (S_I, PID_O, PWM_O) are produced by the datapath, never written.
    localparam logic [PID_DEPTH-1:0] PID_RO_MASK = 16'hE000;

    localparam logic [PID_ADDR_W-1:0] REG_P          = 8'd0;
    localparam logic [PID_ADDR_W-1:0] REG_I          = 8'd1;
    localparam logic [PID_ADDR_W-1:0] REG_D          = 8'd2;
    localparam logic [PID_ADDR_W-1:0] REG_SETPOINT   = 8'd3;
    localparam logic [PID_ADDR_W-1:0] REG_I_MAX      = 8'd4;
    localparam logic [PID_ADDR_W-1:0] REG_I_MIN      = 8'd5;
    localparam logic [PID_ADDR_W-1:0] REG_OUT_MAX    = 8'd6;
    localparam logic [PID_ADDR_W-1:0] REG_OUT_MIN    = 8'd7;
    localparam logic [PID_ADDR_W-1:0] REG_PWM_PERIOD = 8'd8;
    localparam logic [PID_ADDR_W-1:0] REG_PWM_DEAD   = 8'd9;
    localparam logic [PID_ADDR_W-1:0] REG_SAMPLE_DIV = 8'd10;
    localparam logic [PID_ADDR_W-1:0] REG_CTRL       = 8'd11;
    localparam logic [PID_ADDR_W-1:0] REG_PID_O_VAL  = 8'd12;
    localparam logic [PID_ADDR_W-1:0] REG_S_I        = 8'd13;
    localparam logic [PID_ADDR_W-1:0] REG_PID_O      = 8'd14;
    localparam logic [PID_ADDR_W-1:0] REG_PWM_O      = 8'd15;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RD_WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: priority moves to the master not served last
// each time 'advance' is pulsed.
module rr_arb2 (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic prio_q;  // 0: req[0] wins a tie, 1: req[1] wins a tie
    logic last_q;  // index of the most recent grant

    always_comb begin
        gnt[0] = req[0] & (~req[1] | ~prio_q);
        gnt[1] = req[1] & (~req[0] | prio_q);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            prio_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            if (gnt != 2'b00) begin
                last_q <= gnt[1];
            end
            if (advance) begin
                prio_q <= ~last_q;
            end
        end
    end

endmodule

// File: rtl/pid_reg_arbiter.sv
// Serialises two masters onto the PID register file, hides its registered-read latency,
// blocks writes to read-only status registers and returns one response per request.
module pid_reg_arbiter
    import pid_regs_pkg::*;
#(
    parameter int unsigned      ADDR_W  = PID_ADDR_W,
    parameter int unsigned      DATA_W  = PID_DATA_W,
    parameter int unsigned      DEPTH   = PID_DEPTH,
    parameter logic [DEPTH-1:0] RO_MASK = PID_RO_MASK
) (
    input  logic              clk_in,
    input  logic              reset,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic              req0_we_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_rdata_o,
    output logic              rsp0_err_o,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic              req1_we_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_rdata_o,
    output logic              rsp1_err_o,

    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o
);

    arb_state_e        state_q;
    logic              owner_q;
    logic              we_q;
    logic              legal_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        rsp_valid_q;
    logic [1:0]        rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q [2];

    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    logic              arb_advance;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Address must be implemented, and a write must not target a status register.
    function automatic logic access_legal(input logic we, input logic [ADDR_W-1:0] addr);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (addr == ADDR_W'(i)) begin
                ok = !(we && RO_MASK[i]);
            end
        end
        return ok;
    endfunction

    assign arb_req     = {req1_valid_i, req0_valid_i} & {2{(state_q == IDLE) && !reset}};
    assign arb_advance = (state_q == RESP);

    rr_arb2 u_rr_arb2 (
        .clk_in  (clk_in),
        .reset   (reset),
        .req     (arb_req),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    always_comb begin
        sel_we    = req0_we_i;
        sel_addr  = req0_addr_i;
        sel_wdata = req0_wdata_i;
        if (arb_gnt[1]) begin
            sel_we    = req1_we_i;
            sel_addr  = req1_addr_i;
            sel_wdata = req1_wdata_i;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            we_q           <= 1'b0;
            legal_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rsp_valid_q    <= '0;
            rsp_err_q      <= '0;
            rsp_rdata_q[0] <= '0;
            rsp_rdata_q[1] <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        owner_q <= arb_gnt[1];
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        legal_q <= access_legal(sel_we, sel_addr);
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    if (we_q) begin
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_rdata_q[owner_q] <= '0;
                        rsp_err_q[owner_q]   <= !legal_q;
                        state_q              <= RESP;
                    end else begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Reads are only illegal when out of range; return 0 rather than junk.
                    rsp_valid_q[owner_q] <= 1'b1;
                    rsp_rdata_q[owner_q] <= legal_q ? mem_rdata_i : '0;
                    rsp_err_q[owner_q]   <= !legal_q;
                    state_q              <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready_o = arb_gnt[0];
    assign req1_ready_o = arb_gnt[1];

    assign rsp0_valid_o = rsp_valid_q[0];
    assign rsp0_rdata_o = rsp_rdata_q[0];
    assign rsp0_err_o   = rsp_err_q[0];
    assign rsp1_valid_o = rsp_valid_q[1];
    assign rsp1_rdata_o = rsp_rdata_q[1];
    assign rsp1_err_o   = rsp_err_q[1];

    // Reset gates the strobe so an interrupted write never lands.
    assign mem_we_o    = (state_q == CMD) && we_q && legal_q && !reset;
    assign mem_waddr_o = addr_q;
    assign mem_raddr_o = addr_q;
    assign mem_wdata_o = wdata_q;

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_pid_reg_arbiter.sv
// Bench for pid_reg_arbiter: directed and random traffic from both masters against a
// transaction-level model of the register file, arbitration order and response timing.
module tb_pid_reg_arbiter;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } req_t;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        req0_valid_i, req0_ready_o, req0_we_i;
    logic [7:0]  req0_addr_i;
    logic [15:0] req0_wdata_i;
    logic        rsp0_valid_o, rsp0_err_o;
    logic [15:0] rsp0_rdata_o;
    logic        req1_valid_i, req1_ready_o, req1_we_i;
    logic [7:0]  req1_addr_i;
    logic [15:0] req1_wdata_i;
    logic        rsp1_valid_o, rsp1_err_o;
    logic [15:0] rsp1_rdata_o;
    logic        mem_we_o;
    logic [7:0]  mem_waddr_o, mem_raddr_o;
    logic [15:0] mem_wdata_o, mem_rdata_i;
    logic        busy_o;

    pid_reg_arbiter dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_we_i    (req0_we_i),
        .req0_addr_i  (req0_addr_i),
        .req0_wdata_i (req0_wdata_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp0_rdata_o (rsp0_rdata_o),
        .rsp0_err_o   (rsp0_err_o),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_we_i    (req1_we_i),
        .req1_addr_i  (req1_addr_i),
        .req1_wdata_i (req1_wdata_i),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp1_rdata_o (rsp1_rdata_o),
        .rsp1_err_o   (rsp1_err_o),
        .mem_we_o     (mem_we_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_raddr_o  (mem_raddr_o),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o)
    );

    always #5 clk_in = ~clk_in;

    // Register file environment: registered read, junk for unimplemented addresses.
    logic        preload;
    logic [15:0] init_vals [16];
    logic [15:0] mem [16];
    always @(posedge clk_in) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_vals[i];
        end else if (mem_we_o && mem_waddr_o < 8'd16) begin
            mem[mem_waddr_o[3:0]] <= mem_wdata_o;
        end
        mem_rdata_i <= (mem_raddr_o < 8'd16) ? mem[mem_raddr_o[3:0]] : 16'hDEAD;
    end

    int          n_asserts = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          obs_we_cnt = 0;
    int          exp_we_cnt = 0;
    int          last_served;
    logic        rst_drive;
    logic        rand_gap = 1'b0;
    logic [15:0] ref_regs [16];
    req_t        q0[$], q1[$];
    req_t        cur [2];
    req_t        inf [2];
    logic        pend [2];
    logic        inflight [2];
    int          inf_acc [2];
    int          grant_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Legal: implemented address, and status registers 13..15 are never written.
    function automatic logic legal_ref(input req_t r);
        if (r.addr >= 8'd16) return 1'b0;
        if (r.we && r.addr >= 8'd13) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int m, input logic we, input logic [7:0] a, input logic [15:0] d);
        req_t r;
        r.we = we;
        r.addr = a;
        r.wdata = d;
        if (m == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic apply_inputs();
        if (!pend[0] && q0.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            cur[0] = q0.pop_front();
            pend[0] = 1'b1;
        end
        if (!pend[1] && q1.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            cur[1] = q1.pop_front();
            pend[1] = 1'b1;
        end
        reset = rst_drive;
        req0_valid_i = pend[0];
        req0_we_i    = cur[0].we;
        req0_addr_i  = cur[0].addr;
        req0_wdata_i = cur[0].wdata;
        req1_valid_i = pend[1];
        req1_we_i    = cur[1].we;
        req1_addr_i  = cur[1].addr;
        req1_wdata_i = cur[1].wdata;
    endtask

    task automatic sample();
        logic [1:0]  rdy, exp_rdy;
        logic        busy_exp, err_exp;
        logic [15:0] rd_exp;
        logic        rv [2];
        logic        re [2];
        logic [15:0] rd [2];
        int          w;
        rdy = {req1_ready_o, req0_ready_o};
        if (reset) begin
            check("rst_ready", 32'(rdy), 32'(0));
            check("rst_mem_we", 32'(mem_we_o), 32'(0));
            inflight[0] = 1'b0;
            inflight[1] = 1'b0;
            last_served = 1;
            return;
        end
        busy_exp = inflight[0] | inflight[1];
        check("busy", 32'(busy_o), 32'(busy_exp));
        exp_rdy = 2'b00;
        if (!busy_exp) begin
            if (pend[0] && pend[1]) exp_rdy = (last_served == 0) ? 2'b10 : 2'b01;
            else exp_rdy = {pend[1], pend[0]};
        end
        check("ready", 32'(rdy), 32'(exp_rdy));

        rv[0] = rsp0_valid_o; re[0] = rsp0_err_o; rd[0] = rsp0_rdata_o;
        rv[1] = rsp1_valid_o; re[1] = rsp1_err_o; rd[1] = rsp1_rdata_o;
        for (int m = 0; m < 2; m++) begin
            if (rv[m]) begin
                check($sformatf("rsp%0d_expected", m), 32'(inflight[m]), 32'(1));
                if (inflight[m]) begin
                    err_exp = !legal_ref(inf[m]);
                    rd_exp = (!inf[m].we && inf[m].addr < 8'd16) ? ref_regs[inf[m].addr[3:0]] : 16'h0;
                    check($sformatf("rsp%0d_latency", m), 32'(cyc - inf_acc[m]),
                          inf[m].we ? 32'(2) : 32'(3));
                    check($sformatf("rsp%0d_err", m), 32'(re[m]), 32'(err_exp));
                    check($sformatf("rsp%0d_rdata", m), 32'(rd[m]), 32'(rd_exp));
                    if (inf[m].we && !err_exp) begin
                        ref_regs[inf[m].addr[3:0]] = inf[m].wdata;
                        exp_we_cnt++;
                    end
                    inflight[m] = 1'b0;
                    last_served = m;
                end
            end else if (inflight[m] && (cyc - inf_acc[m]) > 3) begin
                check($sformatf("rsp%0d_missing", m), 32'(0), 32'(1));
                inflight[m] = 1'b0;
            end
        end

        if (mem_we_o) begin
            obs_we_cnt++;
            w = inflight[0] ? 0 : 1;
            check("we_in_flight", 32'(inflight[w]), 32'(1));
            if (inflight[w]) begin
                check("we_legal_write", 32'(inf[w].we && legal_ref(inf[w])), 32'(1));
                check("we_cycle", 32'(cyc - inf_acc[w]), 32'(1));
                check("we_waddr", 32'(mem_waddr_o), 32'(inf[w].addr));
                check("we_wdata", 32'(mem_wdata_o), 32'(inf[w].wdata));
            end
        end

        for (int m = 0; m < 2; m++) begin
            if (rdy[m] && pend[m]) begin
                pend[m] = 1'b0;
                inflight[m] = 1'b1;
                inf[m] = cur[m];
                inf_acc[m] = cyc;
                grant_log.push_back(m);
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        cyc++;
        #1;
        apply_inputs();
        @(negedge clk_in);
        sample();
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || pend[0] || pend[1] || inflight[0] ||
                inflight[1]) && n < max_cycles) begin
            step();
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0 || pend[0] || pend[1] || inflight[0] || inflight[1])
            check("drain_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int first;
        int n;
        rst_drive = 1'b1;
        reset = 1'b1;
        preload = 1'b1;
        for (int i = 0; i < 16; i++) init_vals[i] = 16'($urandom);
        init_vals[14] = 16'hBEEF;
        for (int i = 0; i < 16; i++) ref_regs[i] = init_vals[i];
        cur[0] = '0; cur[1] = '0; inf[0] = '0; inf[1] = '0;
        pend[0] = 1'b0; pend[1] = 1'b0; inflight[0] = 1'b0; inflight[1] = 1'b0;
        inf_acc[0] = 0; inf_acc[1] = 0;
        last_served = 1;
        apply_inputs();

        step();
        preload = 1'b0;
        step();
        check("rst_rsp0_valid", 32'(rsp0_valid_o), 32'(0));
        check("rst_rsp1_valid", 32'(rsp1_valid_o), 32'(0));
        check("rst_rsp0_rdata", 32'(rsp0_rdata_o), 32'(0));
        check("rst_rsp1_err", 32'(rsp1_err_o), 32'(0));
        check("rst_mem_addr", 32'({mem_waddr_o, mem_raddr_o}), 32'(0));
        check("rst_mem_wdata", 32'(mem_wdata_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        rst_drive = 1'b0;

        // Basic write, status read, illegal accesses, read-back.
        push(0, 1'b1, 8'd0, 16'h1234);
        drain(20);
        push(1, 1'b0, 8'd14, 16'h0);
        drain(20);
        push(0, 1'b1, 8'd15, 16'h5555);
        drain(20);
        push(0, 1'b1, 8'd20, 16'h7777);
        drain(20);
        push(0, 1'b0, 8'd20, 16'h0);
        drain(20);
        push(1, 1'b0, 8'd0, 16'h0);
        drain(20);

        // Both masters saturated: grants must alternate.
        grant_log.delete();
        first = (last_served == 0) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            push(0, 1'b1, 8'(i), 16'($urandom));
            push(1, 1'b1, 8'(12 - i), 16'($urandom));
        end
        drain(200);
        check("grant_count", 32'(grant_log.size()), 32'(16));
        for (int i = 0; i < grant_log.size(); i++)
            check($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'((first + i) % 2));

        // Reset during the command cycle of a write: nothing lands, no response.
        grant_log.delete();
        push(0, 1'b1, 8'd3, 16'hA5A5);
        n = 0;
        while (grant_log.size() == 0 && n < 10) begin
            step();
            n++;
        end
        check("rst_test_accept", 32'(grant_log.size()), 32'(1));
        rst_drive = 1'b1;
        step();
        rst_drive = 1'b0;
        step();
        push(1, 1'b0, 8'd3, 16'h0);
        drain(20);

        // Random mixed traffic with gaps.
        rand_gap = 1'b1;
        for (int i = 0; i < 60; i++)
            push($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)),
                 16'($urandom));
        drain(2000);
        rand_gap = 1'b0;

        for (int i = 0; i < 16; i++) push(0, 1'b0, 8'(i), 16'h0);
        drain(200);
        check("we_count", 32'(obs_we_cnt), 32'(exp_we_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
